mem_arbiter: RTL and testbench

- Arbitrates the single synchronous memory port between the 6502 core (CPU) and the DMA engine.
- Grants at most one access per cycle and registers the winning request onto the memory bus.
- Routes the read data back to the requester that issued the access.
- Sits between `proc`/`dma` and the memory/peripheral decoder; the CPU treats a missing grant as a wait state.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, grant, read-return and memory bus signals shared
// between the CPU, the DMA engine, the arbiter and the memory decoder.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;

    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;

    logic [7:0]  rd_data;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [1:0]  owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        output rd_data, mem_en, mem_we, mem_addr, mem_wdata, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        input  rd_data, mem_en, mem_we, mem_addr, mem_wdata, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single synchronous memory port between the 6502
// core and the DMA engine. One access per cycle, registered onto the bus;
// read data is steered back by a tag recorded when the read was issued.
// Optional feature macro: ARB_TURNAROUND_EN inserts a dead TURN cycle on
// every owner switch; when undefined ownership switches directly.
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CPU  = 4'b0010,
        DMA  = 4'b0100,
        TURN = 4'b1000
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  burst_cnt;
    logic [7:0]  next_cnt;
    logic        pend_dma;
    logic        next_pend;
    logic        issue_cpu;
    logic        issue_dma;

    logic        cpu_gnt_q;
    logic        dma_gnt_q;
    logic        mem_we_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        rd_pend;
    logic        rd_tag;

    // Decide who gets the bus next cycle; DMA has priority out of IDLE and
    // the burst limit only bites when the CPU is actually waiting.
    always_comb begin
        next_state = state;
        next_cnt   = burst_cnt;
        next_pend  = pend_dma;
        issue_cpu  = 1'b0;
        issue_dma  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.dma_req) begin
                    next_state = DMA;
                    issue_dma  = 1'b1;
                    next_cnt   = 8'd1;
                end else if (bus.cpu_req) begin
                    next_state = CPU;
                    issue_cpu  = 1'b1;
                end
            end
            CPU: begin
                if (bus.dma_req) begin
`ifdef ARB_TURNAROUND_EN
                    next_state = TURN;
                    next_pend  = 1'b1;
`else
                    next_state = DMA;
                    issue_dma  = 1'b1;
                    next_cnt   = 8'd1;
`endif
                end else if (bus.cpu_req) begin
                    issue_cpu = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            DMA: begin
                if (bus.dma_req && !(burst_cnt == BURST_MAX && bus.cpu_req)) begin
                    issue_dma = 1'b1;
                    if (burst_cnt < BURST_MAX)
                        next_cnt = burst_cnt + 8'd1;
                end else begin
                    next_cnt = 8'd0;
                    if (bus.cpu_req) begin
`ifdef ARB_TURNAROUND_EN
                        next_state = TURN;
                        next_pend  = 1'b0;
`else
                        next_state = CPU;
                        issue_cpu  = 1'b1;
`endif
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            TURN: begin
                if (pend_dma) begin
                    if (bus.dma_req) begin
                        next_state = DMA;
                        issue_dma  = 1'b1;
                        next_cnt   = 8'd1;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    if (bus.cpu_req) begin
                        next_state = CPU;
                        issue_cpu  = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 8'd0;
            end
        endcase
    end

    // Register the state, the winning request onto the bus and the read tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            burst_cnt   <= 8'd0;
            pend_dma    <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            dma_gnt_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            rd_pend     <= 1'b0;
            rd_tag      <= 1'b0;
        end else begin
            state     <= next_state;
            burst_cnt <= next_cnt;
            pend_dma  <= next_pend;
            cpu_gnt_q <= issue_cpu;
            dma_gnt_q <= issue_dma;
            if (issue_dma) begin
                mem_we_q    <= bus.dma_we;
                mem_addr_q  <= bus.dma_addr;
                mem_wdata_q <= bus.dma_wdata;
            end else if (issue_cpu) begin
                mem_we_q    <= bus.cpu_we;
                mem_addr_q  <= bus.cpu_addr;
                mem_wdata_q <= bus.cpu_wdata;
            end else begin
                mem_we_q    <= 1'b0;
            end
            rd_pend <= (cpu_gnt_q | dma_gnt_q) & ~mem_we_q;
            if ((cpu_gnt_q | dma_gnt_q) & ~mem_we_q)
                rd_tag <= dma_gnt_q;
        end
    end

    // Owner code follows the one-hot state directly.
    always_comb begin
        unique case (state)
            CPU:     bus.owner = 2'b01;
            DMA:     bus.owner = 2'b10;
            TURN:    bus.owner = 2'b11;
            default: bus.owner = 2'b00;
        endcase
    end

    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.dma_gnt    = dma_gnt_q;
    assign bus.mem_en     = cpu_gnt_q | dma_gnt_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_rvalid = rd_pend & ~rd_tag;
    assign bus.dma_rvalid = rd_pend & rd_tag;
    assign bus.rd_data    = rd_pend ? bus.mem_rdata : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with MAX_BURST = 4,
// covering both the ARB_TURNAROUND_EN and direct-switch builds.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   numChecks = 0;
    int   numErrors = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive both requester ports at once.
    task automatic applyStimulus(input logic cReq, input logic cWe, input logic [15:0] cAddr,
                                 input logic dReq, input logic dWe, input logic [15:0] dAddr,
                                 input logic [7:0] dWdata);
        bus.cpu_req   = cReq;
        bus.cpu_we    = cWe;
        bus.cpu_addr  = cAddr;
        bus.cpu_wdata = 8'h00;
        bus.dma_req   = dReq;
        bus.dma_we    = dWe;
        bus.dma_addr  = dAddr;
        bus.dma_wdata = dWdata;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        reset         = 1'b1;
        bus.mem_rdata = 8'h00;
        applyStimulus(1'b1, 1'b0, 16'hFFFC, 1'b0, 1'b0, 16'h0000, 8'h00);
        tick();
        tick();
        checkOutput("rst_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd0);
        checkOutput("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        checkOutput("rst_owner", {30'd0, bus.owner}, 32'd0);
        checkOutput("rst_mem_addr", {16'd0, bus.mem_addr}, 32'h0);
        checkOutput("rst_rd_data", {24'd0, bus.rd_data}, 32'h0);
        reset = 1'b0;
        #3;
        checkOutput("first_cycle_no_gnt", {31'd0, bus.cpu_gnt}, 32'd0);
        tick();
        checkOutput("boot_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        checkOutput("boot_mem_addr", {16'd0, bus.mem_addr}, 32'hFFFC);
        checkOutput("boot_owner", {30'd0, bus.owner}, 32'd1);
        bus.mem_rdata = 8'h34;
        bus.cpu_req   = 1'b0;
        tick();
        checkOutput("boot_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
        checkOutput("boot_rd_data", {24'd0, bus.rd_data}, 32'h34);
        checkOutput("boot_idle", {30'd0, bus.owner}, 32'd0);

        // Simultaneous requests: DMA first, burst of four, then CPU.
        applyStimulus(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0300, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("burst_dma_gnt", {31'd0, bus.dma_gnt}, 32'd1);
            checkOutput("burst_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd0);
            if (i > 0)
                checkOutput("burst_dma_rvalid", {31'd0, bus.dma_rvalid}, 32'd1);
        end
        tick();
`ifdef ARB_TURNAROUND_EN
        checkOutput("turn_owner", {30'd0, bus.owner}, 32'd3);
        checkOutput("turn_mem_en", {31'd0, bus.mem_en}, 32'd0);
        tick();
`endif
        checkOutput("handover_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        checkOutput("handover_addr", {16'd0, bus.mem_addr}, 32'h1234);
        checkOutput("handover_owner", {30'd0, bus.owner}, 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
        tick();
        checkOutput("handover_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
        checkOutput("handover_idle", {30'd0, bus.owner}, 32'd0);

        // DMA writes 0x0200..0x0207 with no CPU pressure: no burst limit.
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("wr_dma_gnt", {31'd0, bus.dma_gnt}, 32'd1);
            checkOutput("wr_mem_we", {31'd0, bus.mem_we}, 32'd1);
            checkOutput("wr_mem_addr", {16'd0, bus.mem_addr}, 32'h0200 + 32'(i));
            checkOutput("wr_mem_wdata", {24'd0, bus.mem_wdata}, 32'(i));
            checkOutput("wr_no_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
            bus.dma_addr  = 16'h0200 + 16'(i + 1);
            bus.dma_wdata = 8'(i + 1);
            if (i == 7)
                bus.dma_req = 1'b0;
        end
        tick();
        checkOutput("wr_end_gnt", {31'd0, bus.dma_gnt}, 32'd0);
        checkOutput("wr_end_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);

        // CPU read of 0x8000; DMA arrives during the grant cycle.
        applyStimulus(1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 16'h0000, 8'h00);
        tick();
        checkOutput("rd8000_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        checkOutput("rd8000_addr", {16'd0, bus.mem_addr}, 32'h8000);
        checkOutput("rd8000_mem_en", {31'd0, bus.mem_en}, 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0400, 8'h77);
        bus.mem_rdata = 8'h5A;
        tick();
        checkOutput("rd8000_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
        checkOutput("rd8000_rd_data", {24'd0, bus.rd_data}, 32'h5A);
        checkOutput("rd8000_dma_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
`ifdef ARB_TURNAROUND_EN
        checkOutput("rd8000_turn_owner", {30'd0, bus.owner}, 32'd3);
        checkOutput("rd8000_turn_mem_en", {31'd0, bus.mem_en}, 32'd0);
        tick();
`else
        checkOutput("rd8000_direct_mem_en", {31'd0, bus.mem_en}, 32'd1);
`endif
        checkOutput("switch_owner", {30'd0, bus.owner}, 32'd2);
        checkOutput("switch_dma_gnt", {31'd0, bus.dma_gnt}, 32'd1);
        checkOutput("switch_addr", {16'd0, bus.mem_addr}, 32'h0400);
        checkOutput("switch_we", {31'd0, bus.mem_we}, 32'd1);
        bus.dma_req = 1'b0;
        tick();
        checkOutput("switch_idle", {30'd0, bus.owner}, 32'd0);
        checkOutput("switch_no_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);

        // DMA read granted, reset arrives before its data returns.
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0500, 8'h00);
        tick();
        checkOutput("dmard_gnt", {31'd0, bus.dma_gnt}, 32'd1);
        checkOutput("dmard_addr", {16'd0, bus.mem_addr}, 32'h0500);
        reset       = 1'b1;
        bus.dma_req = 1'b0;
        tick();
        checkOutput("midrst_dma_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
        checkOutput("midrst_dma_gnt", {31'd0, bus.dma_gnt}, 32'd0);
        checkOutput("midrst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        checkOutput("midrst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("midrst_addr", {16'd0, bus.mem_addr}, 32'h0);
        checkOutput("midrst_wdata", {24'd0, bus.mem_wdata}, 32'h0);
        checkOutput("midrst_rd_data", {24'd0, bus.rd_data}, 32'h0);
        checkOutput("midrst_owner", {30'd0, bus.owner}, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_idle", {31'd0, bus.mem_en}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
